// File: rtl/ram_loader_if.sv
// Byte-stream handshake between a front end (serial receiver, debouncer) and the RAM loader.
// Latency: none. This is wiring only.
// Backpressure: a byte transfers on a cycle when byte_valid and byte_ready are both high.
interface ram_loader_if #(
    parameter int DATA_W = 8
);
    logic              byte_valid;
    logic [DATA_W-1:0] byte_data;
    logic              byte_ready;

    // Front end drives the byte and its valid flag.
    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready
    );

    // The loader consumes the byte and drives ready.
    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready
    );
endinterface

// File: rtl/ram_loader.sv
// Loads 2^ADDR_W bytes from a valid/ready stream into the program RAM, then releases run.
// Latency: 4 cycles per byte (SETUP, WRITE, HOLD, WAIT); full load with back-to-back bytes gives done at cycle 65.
// Backpressure: byte_ready is high only in WAIT, so the source is stalled during each write cycle.
module ram_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req,
    input  logic              abort,
    ram_loader_if.slave       byte_if,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] prog_data,
    output logic              we,
    output logic              run,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_SETUP  = 3'd2,
        S_WRITE  = 3'd3,
        S_HOLD   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t state;
    state_t next_state;

    // An abort seen during WRITE is remembered so HOLD can still honour it.
    logic abort_pend;

    // byte_ready is a flop that is high exactly when state is WAIT.
    logic handshake;
    assign handshake = byte_if.byte_valid & byte_if.byte_ready;

    // Next-value decode for the registered control outputs.
    logic run_d;
    logic ready_d;
    logic we_d;
    logic busy_d;
    logic done_d;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: abort wins in IDLE/WAIT/SETUP, is deferred across WRITE.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (load_req && !abort) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (handshake) begin
                    next_state = S_SETUP;
                end
            end
            S_SETUP: begin
                next_state = abort ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                next_state = S_HOLD;
            end
            S_HOLD: begin
                if (address == ADDR_LAST) begin
                    next_state = S_FINISH;
                end else if (abort || abort_pend) begin
                    next_state = S_IDLE;
                end else begin
                    next_state = S_WAIT;
                end
            end
            S_FINISH: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every control output can be a flop.
    always_comb begin
        run_d   = (next_state == S_IDLE);
        ready_d = (next_state == S_WAIT);
        we_d    = (next_state == S_WRITE);
        busy_d  = (next_state != S_IDLE);
        done_d  = (next_state == S_FINISH);
    end

    // Control output registers; reset drops we in the same cycle and returns to run mode.
    always_ff @(posedge clock) begin
        if (reset) begin
            run                <= 1'b1;
            byte_if.byte_ready <= 1'b0;
            we                 <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
        end else begin
            run                <= run_d;
            byte_if.byte_ready <= ready_d;
            we                 <= we_d;
            busy               <= busy_d;
            done               <= done_d;
        end
    end

    // Address, data, count and deferred-abort bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            address    <= '0;
            prog_data  <= '0;
            count      <= '0;
            abort_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    abort_pend <= 1'b0;
                    if (load_req && !abort) begin
                        address <= '0;
                        count   <= '0;
                    end
                end
                S_WAIT: begin
                    // A byte offered together with abort is consumed but never written.
                    if (handshake && !abort) begin
                        prog_data <= byte_if.byte_data;
                    end
                end
                S_WRITE: begin
                    abort_pend <= abort;
                end
                S_HOLD: begin
                    abort_pend <= 1'b0;
                    if (count != COUNT_MAX) begin
                        count <= count + (ADDR_W + 1)'(1);
                    end
                    // Address never wraps: it only advances when another byte is expected.
                    if (next_state == S_WAIT) begin
                        address <= address + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
